// File: rtl/mem_line_responder.sv
// mem_line_responder: 128-bit line memory answering mem_read/mem_write with a one-cycle mem_ready after LATENCY cycles.
// Define MEM_JITTER_EN to add 0..3 LFSR-driven extra cycles to each request.
module mem_line_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 8
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [29:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         err_proto,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [8:0] cnt, cnt_nx, load;
    logic [ADDR_W-1:0] idx;
    logic op_wr;
    logic [127:0] wdata;
    logic [127:0] mem [2**ADDR_W];
    logic req, accept, unused_addr;
    assign req = mem_read | mem_write;
    assign accept = (state == IDLE) && req;
    assign unused_addr = ^{mem_addr[29:ADDR_W+2], mem_addr[1:0]};
`ifdef MEM_JITTER_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) lfsr <= 8'h5A;
        else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign load = 9'(LATENCY - 1) + {7'd0, lfsr[1:0]};
`else
    assign load = 9'(LATENCY - 1);
`endif
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            IDLE: if (req) begin
                cnt_nx = load;
                state_nx = (load == 9'd0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_nx = cnt - 9'd1;
                state_nx = (cnt == 9'd1) ? RESP : WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign mem_ready = (state == RESP);
    assign mem_rdata = (mem_ready && !op_wr) ? mem[idx] : '0;
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            op_wr <= 1'b0;
            wdata <= '0;
            err_proto <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (accept) begin
                idx <= mem_addr[ADDR_W+1:2];
                op_wr <= mem_write;
                if (mem_write) wdata <= mem_wdata;
                if (mem_read && mem_write) err_proto <= 1'b1;
            end
            if (mem_ready && op_wr) wr_count <= wr_count + 16'(wr_count != 16'hFFFF);
            if (mem_ready && !op_wr) rd_count <= rd_count + 16'(rd_count != 16'hFFFF);
        end
    end
    // storage is deliberately not reset; an async reset leaves state IDLE so no write commits
    always_ff @(posedge clk) begin
        if (mem_ready && op_wr) mem[idx] <= wdata;
    end
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: randomized line traffic against an array/counter reference model.
module tb_mem_line_responder;
    logic clk = 1'b0;
    logic proc_reset_n;
    logic mem_read, mem_write, mem_ready, err_proto;
    logic [29:0] mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [15:0] rd_count, wr_count;
    logic b_read, b_write, b_ready, b_err;
    logic [29:0] b_addr;
    logic [127:0] b_wdata, b_rdata;
    logic [15:0] b_rd, b_wr;
    int n_checks = 0, n_pass = 0;
    logic [127:0] model [256];
    bit valid [256];
    int exp_rd = 0, exp_wr = 0;
    logic exp_err = 1'b0;
    always #5 clk = ~clk;
    mem_line_responder #(.LATENCY(4), .ADDR_W(8)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err_proto(err_proto), .rd_count(rd_count), .wr_count(wr_count));
    mem_line_responder #(.LATENCY(1), .ADDR_W(8)) dut1 (
        .clk(clk), .proc_reset_n(proc_reset_n), .mem_read(b_read), .mem_write(b_write),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready),
        .err_proto(b_err), .rd_count(b_rd), .wr_count(b_wr));
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_ready"}, mem_ready, 1'b0);
        check({tag, "_rdata"}, mem_rdata, '0);
        check({tag, "_rd"}, rd_count, exp_rd[15:0]);
        check({tag, "_wr"}, wr_count, exp_wr[15:0]);
        check({tag, "_err"}, err_proto, exp_err);
    endtask
    task automatic do_req(input logic rd, input logic wr, input logic [29:0] addr, input logic [127:0] data);
        logic [7:0] idx;
        logic [127:0] exp_data;
        int lat;
        idx = addr[9:2];
        exp_data = model[idx];
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = data;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_ready) break;
            mem_addr = 30'($urandom);
            mem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
`ifdef MEM_JITTER_EN
        check("latency_range", (lat >= 4 && lat <= 7), 1'b1);
`else
        check("latency", 32'(lat), 32'd4);
`endif
        if (!wr) check("rdata", mem_rdata, exp_data);
        mem_read = 1'b0; mem_write = 1'b0;
        if (wr) begin
            model[idx] = data;
            valid[idx] = 1'b1;
            exp_wr = (exp_wr < 65535) ? exp_wr + 1 : exp_wr;
        end else exp_rd = (exp_rd < 65535) ? exp_rd + 1 : exp_rd;
        if (rd && wr) exp_err = 1'b1;
        @(negedge clk);
        check_idle("post");
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [127:0] d;
        logic [29:0] a;
        proc_reset_n = 1'b0;
        {mem_read, mem_write, b_read, b_write} = '0;
        mem_addr = '0; mem_wdata = '0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        proc_reset_n = 1'b1;
        do_req(1'b0, 1'b1, 30'h0C, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        do_req(1'b1, 1'b0, 30'h0E, '0);
        do_req(1'b1, 1'b1, 30'h10, {16{8'hA5}});
        do_req(1'b1, 1'b0, 30'h10, '0);
        do_req(1'b0, 1'b1, 30'h14, 128'h5555_0000_1111_2222_3333_4444_6666_7777);
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 30'h14; mem_wdata = {8{16'hDEAD}};
        repeat (2) @(negedge clk);
        #2 proc_reset_n = 1'b0;
        #1;
        mem_write = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
        check_idle("abort");
        repeat (3) begin
            @(negedge clk);
            check("abort_ready", mem_ready, 1'b0);
        end
        proc_reset_n = 1'b1;
        do_req(1'b1, 1'b0, 30'h14, '0);
        do_req(1'b0, 1'b1, 30'h400, 128'hCAFE_F00D_0000_0001_0000_0002_BEEF_0003);
        do_req(1'b1, 1'b0, 30'h000, '0);
        for (int i = 0; i < 40; i++) begin
            a = 30'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            if (valid[a[9:2]] && $urandom_range(1)) do_req(1'b1, 1'b0, a, '0);
            else if ($urandom_range(7) == 0) do_req(1'b1, 1'b1, a, d);
            else do_req(1'b0, 1'b1, a, d);
        end
`ifndef MEM_JITTER_EN
        d = 128'h1357_9BDF_2468_ACE0_0F0F_F0F0_AAAA_5555;
        @(negedge clk);
        b_write = 1'b1; b_addr = 30'h1C; b_wdata = d;
        @(negedge clk);
        check("l1_wr_ready", b_ready, 1'b1);
        b_write = 1'b0;
        @(negedge clk);
        check("l1_wr_gap", b_ready, 1'b0);
        b_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("l1_pulse", b_ready, (i % 2) == 0);
            check("l1_rdata", b_rdata, ((i % 2) == 0) ? d : '0);
        end
        b_read = 1'b0;
        @(negedge clk);
        check("l1_rd_count", b_rd, 16'd3);
        check("l1_wr_count", b_wr, 16'd1);
        check("l1_err", b_err, 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the 128-bit line interface driven by the L1 caches.
- Services one line read or line write per request and returns a single-cycle `mem_ready` after a programmable latency.
- Backs a DEPTH-line storage array and keeps saturating request counters for bench and debug visibility.
- Sits between the cache `mem_*` ports and the testbench/top level, replacing an ideal memory.

Parameters:
- LATENCY, 4: cycles from request acceptance to the `mem_ready` cycle; legal range 1..255.
- ADDR_W, 8: line-index width; DEPTH = 2**ADDR_W lines of 128 bits.

Ports:
- clk  in  1  single clock, rising edge.
- proc_reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  line read request; held high by the requester until `mem_ready`.
- mem_write  in  1  line write request; held high by the requester until `mem_ready`.
- mem_addr  in  30  word address; line index = mem_addr[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 are ignored.
- mem_wdata  in  128  write line; word k is bits [32k+31:32k].
- mem_rdata  out  128  read line; valid only while `mem_ready`=1.
- mem_ready  out  1  one-cycle completion pulse.
- err_proto  out  1  sticky flag: read and write were both high at acceptance.
- rd_count  out  16  saturating count of completed reads.
- wr_count  out  16  saturating count of completed writes.

Behaviour:
- Reset (asynchronous, proc_reset_n=0):
  - state=IDLE; mem_ready=0; mem_rdata=0; err_proto=0; rd_count=0; wr_count=0; latency counter=0.
  - Storage contents are not cleared.
  - Reset asserted mid-operation aborts the request immediately; no write is committed and no `mem_ready` is issued.
- States:
  - IDLE: on a rising edge with mem_read|mem_write=1:
    - latch line index, op and (for writes) mem_wdata;
    - load counter = LATENCY-1;
    - go to WAIT if LATENCY>1, else to RESP.
  - WAIT: decrement the counter each cycle; when the counter reaches 0, go to RESP.
  - RESP: drive mem_ready=1 for exactly one cycle, then go to IDLE.
    - Read: mem_rdata = storage[latched index] during this cycle.
    - Write: storage[latched index] <= latched wdata on the edge that ends RESP.
    - Increment the matching counter on that same edge; counters saturate at 16'hFFFF.
- Timing:
  - Request sampled at edge E0 gives mem_ready=1 during the cycle following edge E0+LATENCY-1.
  - Total latency from the request cycle to the ready cycle is LATENCY cycles.
- Request inputs are ignored outside IDLE; address and data changes during WAIT/RESP have no effect (values are latched).
- The cycle after RESP is always IDLE, so back-to-back requests have a minimum spacing of LATENCY+1 cycles. This matches the caches' registered deassertion of `mem_read`.
- Simultaneous mem_read and mem_write at acceptance:
  - the write is serviced and the read is dropped;
  - err_proto is set and stays set until reset.
- Addresses at or beyond DEPTH lines wrap modulo DEPTH.
- mem_rdata returns to 0 outside RESP.

Optional Feature:
- MEM_JITTER_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h5A at reset; advances every cycle) adds extra cycles to each request.
  - At acceptance, LFSR[1:0] (0..3) is added to the counter load.
  - Each request then completes in LATENCY..LATENCY+3 cycles.
- MEM_JITTER_EN undefined: latency is exactly LATENCY; no LFSR exists.

Test Plan:
- Reset, then write line 3 (mem_addr=30'h0C) with 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> mem_ready is a single pulse 4 cycles after the request cycle; wr_count=1.
- Read mem_addr=30'h0E (same line, offset 2) -> mem_rdata equals the written line while mem_ready=1; rd_count=1; mem_rdata=0 on the following cycle.
- LATENCY=1 instance: a read is acknowledged in the cycle immediately after the request cycle. A re-raised request in the cycle after RESP is accepted, giving 2-cycle spacing.
- mem_read and mem_write both high at addr 30'h10 with mem_wdata=128'hA5..A5 -> write is committed, err_proto=1, rd_count unchanged. A subsequent read of 30'h10 returns 128'hA5..A5.
- Pull proc_reset_n low during WAIT of a write to line 5 -> mem_ready stays 0 and all outputs return to reset values. A subsequent read of line 5 returns the old contents.
- Address wrap with ADDR_W=8: write at mem_addr=30'h400 (line 256), then read at 30'h000 -> same data returned.
